// File: rtl/dsp_post_adder_acc.sv
// dsp_post_adder_acc: DSP48A1 post-adder / accumulator stage.
// X/Z operand muxes, add/sub with carry-in, registered P and CARRYOUT.
module dsp_post_adder_acc #(
    parameter bit OPMODEREG  = 1'b1,
    parameter bit CARRYINREG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_opmode,
    input  logic        ce_carryin,
    input  logic        ce_p,
    input  logic [4:0]  opmode,
    input  logic [35:0] m,
    input  logic [47:0] dab,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic        carry_in,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carry_out
);

    logic [4:0]  r_opmode;
    logic        r_carryin;
    logic [47:0] r_p;
    logic        r_carry_out;

    logic [4:0]  w_opmode;
    logic        w_cin;
    logic [47:0] w_x;
    logic [47:0] w_z;
    logic [48:0] w_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opmode <= '0;
        end else if (ce_opmode) begin
            r_opmode <= opmode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carryin <= 1'b0;
        end else if (ce_carryin) begin
            r_carryin <= carry_in;
        end
    end

    assign w_opmode = OPMODEREG  ? r_opmode  : opmode;
    assign w_cin    = CARRYINREG ? r_carryin : carry_in;

    always_comb begin
        w_x = '0;
        unique case (w_opmode[1:0])
            2'd0: w_x = '0;
            2'd1: w_x = {{12{m[35]}}, m};
            2'd2: w_x = r_p;
            2'd3: w_x = dab;
        endcase
    end

    always_comb begin
        w_z = '0;
        unique case (w_opmode[3:2])
            2'd0: w_z = '0;
            2'd1: w_z = pcin;
            2'd2: w_z = r_p;
            2'd3: w_z = c;
        endcase
    end

    // On subtract, bit 48 of the 49-bit result is the borrow.
    always_comb begin
        w_r = '0;
        if (w_opmode[4]) begin
            w_r = {1'b0, w_z} - ({1'b0, w_x} + {48'd0, w_cin});
        end else begin
            w_r = {1'b0, w_z} + {1'b0, w_x} + {48'd0, w_cin};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p         <= '0;
            r_carry_out <= 1'b0;
        end else if (ce_p) begin
            r_p         <= w_r[47:0];
            r_carry_out <= w_r[48];
        end
    end

    assign p         = r_p;
    assign pcout     = r_p;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb_dsp_post_adder_acc: directed and random checks of the post-adder
// against an arithmetic reference model of the slice's P path.
module tb_dsp_post_adder_acc;

    logic        clk;
    logic        rst;
    logic        ce_opmode;
    logic        ce_carryin;
    logic        ce_p;
    logic [4:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        carry_in;
    logic [47:0] p;
    logic [47:0] pcout;
    logic        carry_out;

    int total = 0;
    int bad   = 0;

    logic [47:0] mp;
    logic        mco;
    logic [4:0]  mop;
    logic        mci;

    localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint unsigned MASK49 = 64'h0001_FFFF_FFFF_FFFF;

    dsp_post_adder_acc dut (
        .clk       (clk),
        .rst       (rst),
        .ce_opmode (ce_opmode),
        .ce_carryin(ce_carryin),
        .ce_p      (ce_p),
        .opmode    (opmode),
        .m         (m),
        .dab       (dab),
        .c         (c),
        .pcin      (pcin),
        .carry_in  (carry_in),
        .p         (p),
        .pcout     (pcout),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] ref_next(
        input logic [4:0]  op,
        input logic        ci,
        input logic [35:0] mm,
        input logic [47:0] dd,
        input logic [47:0] cc,
        input logic [47:0] pc,
        input logic [47:0] pp
    );
        longint          sm;
        longint unsigned x;
        longint unsigned z;
        longint unsigned r;
        sm = longint'($signed(mm));
        case (op[1:0])
            2'd0:    x = 0;
            2'd1:    x = longint'(sm) & MASK48;
            2'd2:    x = {16'd0, pp};
            default: x = {16'd0, dd};
        endcase
        case (op[3:2])
            2'd0:    z = 0;
            2'd1:    z = {16'd0, pc};
            2'd2:    z = {16'd0, pp};
            default: z = {16'd0, cc};
        endcase
        if (op[4]) r = (z - (x + 64'(ci))) & MASK49;
        else       r = (z + x + 64'(ci)) & MASK49;
        return r[48:0];
    endfunction

    task automatic chk(input string tag, input logic [48:0] obs,
                       input logic [48:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".p"}, {1'b0, p}, {1'b0, mp});
        chk({tag, ".pcout"}, {1'b0, pcout}, {1'b0, mp});
        chk({tag, ".co"}, {48'd0, carry_out}, {48'd0, mco});
    endtask

    task automatic model_clear();
        mp  = '0;
        mco = 1'b0;
        mop = '0;
        mci = 1'b0;
    endtask

    // One clock edge; model advances from the pre-edge inputs.
    task automatic step();
        logic [48:0] nx;
        logic [4:0]  op_in;
        logic        ci_in;
        logic        cep, ceo, cec;
        nx    = ref_next(mop, mci, m, dab, c, pcin, mp);
        op_in = opmode;
        ci_in = carry_in;
        cep   = ce_p;
        ceo   = ce_opmode;
        cec   = ce_carryin;
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
        end else begin
            if (cep) {mco, mp} = nx;
            if (ceo) mop = op_in;
            if (cec) mci = ci_in;
        end
    endtask

    initial begin
        rst        = 1'b1;
        ce_opmode  = 1'b1;
        ce_carryin = 1'b1;
        ce_p       = 1'b1;
        opmode     = '0;
        m          = '0;
        dab        = '0;
        c          = '0;
        pcin       = '0;
        carry_in   = 1'b0;
        model_clear();
        #2;
        chk("rst.p", {1'b0, p}, 49'd0);
        chk("rst.pcout", {1'b0, pcout}, 49'd0);
        chk("rst.co", {48'd0, carry_out}, 49'd0);
        step();
        step();
        rst = 1'b0;

        opmode = 5'b0_00_11;
        dab    = 48'h1234;
        step();
        step();
        chk("load1234", {1'b0, p}, 49'h1234);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        chk("async.p", {1'b0, p}, 49'd0);
        chk("async.co", {48'd0, carry_out}, 49'd0);
        step();
        chk("rsthold.p", {1'b0, p}, 49'd0);
        rst = 1'b0;

        opmode = 5'b0_10_01;
        m      = 36'd5;
        step();
        chk("mac0", {1'b0, p}, 49'd0);
        step();
        chk("mac5", {1'b0, p}, 49'd5);
        step();
        chk("mac10", {1'b0, p}, 49'd10);
        step();
        chk("mac15", {1'b0, p}, 49'd15);
        step();
        chk("mac20", {1'b0, p}, 49'd20);
        ce_p = 1'b0;
        step();
        chk("hold1.p", {1'b0, p}, 49'd20);
        step();
        chk("hold2.pcout", {1'b0, pcout}, 49'd20);
        ce_p   = 1'b1;
        opmode = 5'b0_01_00;
        pcin   = 48'd7;
        step();
        chk("casc.old", {1'b0, p}, 49'd25);
        step();
        chk("casc.p7", {1'b0, p}, 49'd7);

        ce_p   = 1'b0;
        opmode = 5'b0_00_11;
        dab    = 48'd99;
        step();
        chk("opld.phold", {1'b0, p}, 49'd7);
        ce_p = 1'b1;
        step();
        chk("opld.new", {1'b0, p}, 49'd99);
        ce_opmode = 1'b0;
        opmode    = 5'b0_11_00;
        c         = 48'd5;
        step();
        chk("ceop.hold", {1'b0, p}, 49'd99);
        ce_opmode = 1'b1;

        opmode = 5'b0_00_01;
        m      = 36'hF_FFFF_FFFF;
        step();
        step();
        chk("sext.p", {1'b0, p}, 49'hFFFF_FFFF_FFFF);
        chk("sext.co", {48'd0, carry_out}, 49'd0);

        opmode   = 5'b0_11_11;
        c        = 48'hFFFF_FFFF_FFFF;
        dab      = 48'd1;
        carry_in = 1'b0;
        step();
        step();
        chk("wrap.p", {1'b0, p}, 49'd0);
        chk("wrap.co", {48'd0, carry_out}, 49'd1);

        opmode   = 5'b1_11_11;
        c        = 48'd100;
        dab      = 48'd30;
        carry_in = 1'b1;
        step();
        step();
        chk("sub.p", {1'b0, p}, 49'd69);
        chk("sub.co", {48'd0, carry_out}, 49'd0);
        c        = 48'd0;
        dab      = 48'd1;
        carry_in = 1'b0;
        step();
        step();
        chk("borrow.p", {1'b0, p}, 49'hFFFF_FFFF_FFFF);
        chk("borrow.co", {48'd0, carry_out}, 49'd1);
        cmp_model("dir");

        for (int i = 0; i < 300; i++) begin
            opmode     = 5'($urandom);
            m          = {4'($urandom), 32'($urandom)};
            dab        = {16'($urandom), 32'($urandom)};
            c          = {16'($urandom), 32'($urandom)};
            pcin       = {16'($urandom), 32'($urandom)};
            carry_in   = 1'($urandom);
            ce_p       = ($urandom_range(0, 3) != 0);
            ce_opmode  = ($urandom_range(0, 3) != 0);
            ce_carryin = ($urandom_range(0, 3) != 0);
            if (i == 150) begin
                #3;
                rst = 1'b1;
                #1;
                model_clear();
                cmp_model("rnd.async");
                step();
                rst = 1'b0;
            end
            step();
            cmp_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_post_adder_acc.md
# dsp_post_adder_acc

Post-adder/accumulator stage of the DSP48A1 slice model, directly downstream of the multiplier's M pipeline register. It selects X and Z operands from the M product, the D:A:B concatenation, the C port, the cascade input and its own P feedback, then adds or subtracts with carry-in. The result and carry-out are registered into the P and CARRYOUT registers. P drives both the slice output and the PCOUT cascade to the next slice.

## Interface
- OPMODEREG, default 1: 1 registers opmode; 0 uses opmode combinationally.
- CARRYINREG, default 1: 1 registers carry_in; 0 uses carry_in combinationally.
- Reset: rst, asynchronous, active-high, clears every register in the block. Clock: clk.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ce_opmode  in  1  clock enable, OPMODE register
- ce_carryin  in  1  clock enable, CARRYIN register
- ce_p  in  1  clock enable, P and CARRYOUT registers
- opmode  in  5  bit [1:0] x_sel, bit [3:2] z_sel, bit [4] sub
- m  in  36  signed product from the M register
- dab  in  48  D[11:0]:A[17:0]:B[17:0] concatenation
- c  in  48  C operand
- pcin  in  48  cascade input from the previous slice
- carry_in  in  1  post-adder carry-in
- p  out  48  P register
- pcout  out  48  cascade output, identical to p
- carry_out  out  1  CARRYOUT register

## Operation
- X mux, selected by x_sel:
  - 0: zero
  - 1: m sign-extended to 48 bits (bit 35 replicated)
  - 2: p
  - 3: dab
- Z mux, selected by z_sel:
  - 0: zero
  - 1: pcin
  - 2: p
  - 3: c
- Arithmetic is 49-bit unsigned on zero-extended operands:
  - sub=0: r = Z + X + cin
  - sub=1: r = Z − (X + cin)
- Next p = r[47:0], wrapping modulo 2^48. Next carry_out = r[48]; for sub=1 this bit is the borrow.
- opmode and cin used by the adder come from their registers when OPMODEREG/CARRYINREG=1, otherwise straight from the ports.
- P feedback on X or Z always uses the current registered p. Selecting P on both X and Z is legal and doubles p.
- ce_p=0: p and carry_out hold. The adder keeps evaluating but nothing is captured.
- ce_opmode=0 and ce_carryin=0 hold their registers independently of ce_p.
- pcout is a plain wire copy of p, with no extra delay.

## Timing
- Reset values: p=0, pcout=0, carry_out=0, opmode register=0 (X=0, Z=0, add), carry-in register=0.
- rst clears all registers immediately, with no clock edge needed. While rst is high it overrides every CE. The first capture happens on the first rising edge after rst falls.
- Latency from m, dab, c, pcin to p/carry_out: 1 cycle.
- Latency from opmode/carry_in to result: 2 cycles when the matching *REG=1, 1 cycle when it is 0.
- Opmode change with OPMODEREG=1: the edge that loads the new opmode still computes p with the old opmode.
- rst during accumulation: the accumulation restarts from p=0 on the next enabled edge.
- Simultaneous ce_p=0 and an opmode register load: the opmode updates and p holds.

## Test plan
- Async reset: load p=48'h1234, then assert rst between clock edges → p=0 and carry_out=0 before the next edge, and they stay 0 while rst is high even with ce_p=1.
- MAC: opmode=5'b0_10_01 (Z=P, X=M, add), m=5, ce all 1, starting from reset, OPMODEREG=1 → p=0 (opmode latency), then 5, 10, 15, 20 on successive edges.
- Sign extension: opmode=5'b0_00_01, m=36'hF_FFFF_FFFF → p=48'hFFFF_FFFF_FFFF, carry_out=0.
- Wrap/carry: opmode=5'b0_11_11, c=48'hFFFF_FFFF_FFFF, dab=1, cin=0 → p=0, carry_out=1.
- Subtract with carry-in:
  - opmode=5'b1_11_11, c=100, dab=30, cin=1 → p=69, carry_out=0.
  - Then c=0, dab=1, cin=0 → p=48'hFFFF_FFFF_FFFF, carry_out=1.
- Enables/cascade: during the MAC scenario drop ce_p for 2 cycles → p and pcout hold at their value. Switch z_sel to 1 with pcin=7 and X=0 → p=7 exactly 2 edges after the opmode is presented (OPMODEREG=1).
